// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the iterative signed divider.
// The master drives the request and operands. The slave returns status and results.
`timescale 1ns/1ps
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring signed divider: 2W-bit dividend / W-bit divisor, one bit per clock, done 2W+1 edges after start.
// One operation in flight; start is ignored while busy, and a zero divisor completes on the start edge.
`timescale 1ns/1ps
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave dif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int         CW   = $clog2(2*WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2*WIDTH-1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] dvd;
  logic [WIDTH-1:0]   dsr;
  logic [WIDTH-1:0]   prem;
  logic               sign_q;
  logic               sign_r;

  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [2*WIDTH-1:0] q_full;
  logic [2*WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0]   dsr_abs;

  // dvd doubles as the dividend shifter and the quotient accumulator:
  // dividend bits leave at the top while quotient bits enter at the bottom.
  always_comb begin
    shifted = {prem, dvd[2*WIDTH-1]};
    ge      = shifted >= {1'b0, dsr};
    q_full  = sign_q ? -dvd : dvd;
    dvd_abs = dif.dividend[2*WIDTH-1] ? -dif.dividend : dif.dividend;
    dsr_abs = dif.divisor[WIDTH-1] ? -dif.divisor : dif.divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      dvd             <= '0;
      dsr             <= '0;
      prem            <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      dif.busy        <= 1'b0;
      dif.done        <= 1'b0;
      dif.quotient    <= '0;
      dif.remainder   <= '0;
      dif.div_by_zero <= 1'b0;
      dif.overflow    <= 1'b0;
    end else begin
      dif.done <= 1'b0;
      case (state)
        IDLE: begin
          if (dif.start) begin
            dif.overflow <= 1'b0;
            if (dif.divisor == '0) begin
              dif.quotient    <= '0;
              dif.remainder   <= '0;
              dif.div_by_zero <= 1'b1;
              dif.done        <= 1'b1;
            end else begin
              dif.div_by_zero <= 1'b0;
              dvd      <= dvd_abs;
              dsr      <= dsr_abs;
              prem     <= '0;
              sign_q   <= dif.dividend[2*WIDTH-1] ^ dif.divisor[WIDTH-1];
              sign_r   <= dif.dividend[2*WIDTH-1];
              cnt      <= '0;
              dif.busy <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          // prem < |divisor| <= 2^(W-1), so the difference always fits in W bits
          prem <= ge ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
          dvd  <= {dvd[2*WIDTH-2:0], ge};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          dif.quotient  <= q_full[WIDTH-1:0];
          dif.remainder <= sign_r ? -prem : prem;
          // representable only if the upper W+1 bits are a pure sign extension
          dif.overflow  <= ~((&q_full[2*WIDTH-1:WIDTH-1]) | ~(|q_full[2*WIDTH-1:WIDTH-1]));
          dif.done      <= 1'b1;
          dif.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, handshake/reset corner sequences and a random sweep,
// with expected results queued at start and compared when done is seen.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int W = 32;

  typedef struct {
    logic [63:0] dvd;
    logic [31:0] dsr;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) dif ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .dif(dif));

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  vec_t tbl[12];

  function automatic vec_t mk(input logic [63:0] dvd, input logic [31:0] dsr, input logic [31:0] q,
                              input logic [31:0] r, input logic dbz, input logic ovf);
    vec_t v;
    v.dvd = dvd; v.dsr = dsr; v.q = q; v.r = r; v.dbz = dbz; v.ovf = ovf;
    v.lat = dbz ? 0 : 65;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (dif.done !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic launch(input string tag, input vec_t v);
    exp_q.push_back(v);
    dif.dividend = v.dvd;
    dif.divisor  = v.dsr;
    dif.start    = 1'b1;
    step();
    dif.start = 1'b0;
    chk({tag, "_busy_at_start"}, dif.busy, !v.dbz);
  endtask

  task automatic finish_op(input string tag, input int extra);
    int   cyc;
    vec_t e;
    wait_done(cyc);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_sb: done seen with empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_lat"},  cyc + extra, e.lat);
      chk({tag, "_q"},    dif.quotient, e.q);
      chk({tag, "_r"},    dif.remainder, e.r);
      chk({tag, "_dbz"},  dif.div_by_zero, e.dbz);
      chk({tag, "_ovf"},  dif.overflow, e.ovf);
      chk({tag, "_busy"}, dif.busy, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   spurious;
    int   cyc;
    vec_t v;
    vec_t v2;

    tbl[0]  = mk(64'hFFFF_FFFF_FFFF_FFEC, 32'd4,          32'hFFFF_FFFB, 32'd0,          1'b0, 1'b0);
    tbl[1]  = mk(64'd7,                   32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,          1'b0, 1'b0);
    tbl[2]  = mk(64'hFFFF_FFFF_FFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF,  1'b0, 1'b0);
    tbl[3]  = mk(64'hFFFF_FFFF_FFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF,  1'b0, 1'b0);
    tbl[4]  = mk(64'd123,                 32'd0,          32'd0,         32'd0,          1'b1, 1'b0);
    tbl[5]  = mk(64'h0000_0100_0000_0000, 32'd1,          32'd0,         32'd0,          1'b0, 1'b1);
    tbl[6]  = mk(64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,          1'b0, 1'b1);
    tbl[7]  = mk(64'h8000_0000_0000_0000, 32'h8000_0000,  32'd0,         32'd0,          1'b0, 1'b1);
    tbl[8]  = mk(64'hFFFF_FFFF_8000_0000, 32'd1,          32'h8000_0000, 32'd0,          1'b0, 1'b0);
    tbl[9]  = mk(64'h0000_0000_7FFF_FFFF, 32'd1,          32'h7FFF_FFFF, 32'd0,          1'b0, 1'b0);
    tbl[10] = mk(64'd5,                   32'd7,          32'd0,         32'd5,          1'b0, 1'b0);
    tbl[11] = mk(64'd100,                 32'd7,          32'd14,        32'd2,          1'b0, 1'b0);

    dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    rst = 1'b1;
    step(); step();
    chk("rst_busy", dif.busy, 1'b0);
    chk("rst_done", dif.done, 1'b0);
    chk("rst_q",    dif.quotient, 32'd0);
    chk("rst_r",    dif.remainder, 32'd0);
    chk("rst_dbz",  dif.div_by_zero, 1'b0);
    chk("rst_ovf",  dif.overflow, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      launch($sformatf("vec%0d", i), tbl[i]);
      finish_op($sformatf("vec%0d", i), 0);
      step();
      chk($sformatf("vec%0d_done_pulse", i), dif.done, 1'b0);
      chk($sformatf("vec%0d_q_hold", i), dif.quotient, tbl[i].q);
      step();
    end

    // second start at cycle 10 must not disturb the operation in flight
    v = mk(64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);
    launch("ign", v);
    for (int i = 0; i < 9; i++) step();
    dif.dividend = 64'd77; dif.divisor = 32'd3; dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    finish_op("ign", 10);
    step();
    chk("ign_no_second_op", dif.busy, 1'b0);
    step();

    // start held through the done cycle is accepted back-to-back
    v  = mk(64'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 32'd6, 1'b0, 1'b0);
    v2 = mk(64'hFFFF_FFFF_FFFF_FC18, 32'd7, 32'hFFFF_FF72, 32'hFFFF_FFFA, 1'b0, 1'b0);
    launch("b2b_a", v);
    finish_op("b2b_a", 0);
    launch("b2b_b", v2);
    chk("b2b_no_done_while_busy", dif.done, 1'b0);
    finish_op("b2b_b", 0);
    step();

    // reset at cycle 30 abandons the operation without a done pulse
    v = mk(64'd500, 32'd3, 32'd166, 32'd2, 1'b0, 1'b0);
    launch("mid_rst", v);
    spurious = 0;
    for (int i = 0; i < 29; i++) begin
      step();
      if (dif.done === 1'b1) spurious++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_no_done", spurious, 0);
    chk("mid_rst_busy", dif.busy, 1'b0);
    chk("mid_rst_done", dif.done, 1'b0);
    chk("mid_rst_q",    dif.quotient, 32'd0);
    chk("mid_rst_r",    dif.remainder, 32'd0);
    launch("post_rst", tbl[11]);
    finish_op("post_rst", 0);
    step();

    // random sweep against a behavioural signed-division model
    for (int i = 0; i < 16; i++) begin
      longint sd, sv, q64, r64;
      sd = longint'({$urandom, $urandom}) >>> $urandom_range(0, 63);
      sv = longint'(int'($urandom) >>> $urandom_range(0, 31));
      if (sv == 0) sv = 1;
      if (sd == 64'sh8000_0000_0000_0000 && sv == -1) sd = 1;
      q64 = sd / sv;
      r64 = sd % sv;
      v.dvd = sd;
      v.dsr = sv[31:0];
      v.q   = q64[31:0];
      v.r   = r64[31:0];
      v.dbz = 1'b0;
      v.ovf = (q64 > 64'sd2147483647) || (q64 < -64'sd2147483648);
      v.lat = 65;
      launch($sformatf("rnd%0d", i), v);
      finish_op($sformatf("rnd%0d", i), 0);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
